// File: rtl/av_progressive_dot_engine_pkg.sv
// Shared types and latency constants for the progressive-precision A*V dot-product engine.
package av_dot_pkg;

    typedef enum logic [1:0] {
        PREC_INT4 = 2'd0,
        PREC_INT8 = 2'd1,
        PREC_16   = 2'd2,
        PREC_RSVD = 2'd3
    } prec_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dot_state_e;

    // Issue-to-retire latency of each multiplier exit, in clk edges.
    localparam int LAT_INT4  = 2;
    localparam int LAT_INT8  = 3;
    localparam int LAT_INT16 = 5;

    function automatic logic [15:0] mask_operand(prec_mode_e m, logic [15:0] x);
        case (m)
            PREC_INT4: return {12'h000, x[3:0]};
            PREC_INT8: return {8'h00, x[7:0]};
            default:   return x;
        endcase
    endfunction

endpackage

// File: rtl/av_progressive_dot_engine_if.sv
// Command, operand-stream and result handshake bundle of the dot-product engine.
interface av_dot_if #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int ACC_W   = 32 + LEN_W
);
    logic             start;
    logic [1:0]       mode;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      a;
    logic [15:0]      b;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic [1:0]       res_mode;

    modport master (
        output start, mode, len, in_valid, a, b, res_ready,
        input  in_ready, busy, res_valid, res_data, res_mode
    );

    modport slave (
        input  start, mode, len, in_valid, a, b, res_ready,
        output in_ready, busy, res_valid, res_data, res_mode
    );
endinterface

// File: rtl/av_progressive_dot_engine_mul.sv
// Progressive-precision multiplier: INT4, INT8 and full-width products exit at different depths.
module mul16_progressive
    import av_dot_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out4_valid,
    output logic [7:0]         p4,
    output logic               out8_valid,
    output logic [15:0]        p8,
    output logic               out16_valid,
    output logic [2*WIDTH-1:0] p16
);

    logic [LAT_INT16:1]  vld;
    logic [WIDTH-1:0]    a1, b1, a2, b2, a3, b3;
    logic [WIDTH+7:0]    part_lo;
    logic [2*WIDTH-9:0]  part_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld <= '0;
        else        vld <= {vld[LAT_INT16-1:1], in_valid};
    end

    // NOTE: datapath registers carry no reset; the valid chain alone qualifies them.
    always_ff @(posedge clk) begin
        a1      <= a;
        b1      <= b;
        p4      <= 8'(a1[3:0]) * 8'(b1[3:0]);
        a2      <= a1;
        b2      <= b1;
        p8      <= 16'(a2[7:0]) * 16'(b2[7:0]);
        a3      <= a2;
        b3      <= b2;
        // Full-width product split on b so each stage holds a narrower multiply.
        part_lo <= (WIDTH+8)'(a3) * (WIDTH+8)'(b3[7:0]);
        part_hi <= (2*WIDTH-8)'(a3) * (2*WIDTH-8)'(b3[WIDTH-1:8]);
        p16     <= (2*WIDTH)'(part_lo) + {part_hi, 8'h00};
    end

    assign out4_valid  = vld[LAT_INT4];
    assign out8_valid  = vld[LAT_INT8];
    assign out16_valid = vld[LAT_INT16];

endmodule

// File: rtl/av_progressive_dot_engine.sv
// A*V dot-product engine: streams operand pairs into the progressive multiplier and sums the
// product tap matching the active precision.
module av_progressive_dot_engine
    import av_dot_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int ACC_W   = 32 + LEN_W
) (
    input logic     clk,
    input logic     rst,
    av_dot_if.slave bus
);

    dot_state_e       state;
    prec_mode_e       mode_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issue_cnt;
    logic [LEN_W-1:0] retire_cnt;
    logic [ACC_W-1:0] acc;

    logic [LEN_W-1:0] len_clamped;
    logic [LEN_W-1:0] issue_cnt_nxt;
    logic [LEN_W-1:0] retire_cnt_nxt;
    logic [ACC_W-1:0] acc_nxt;

    logic             issue_fire;
    logic [15:0]      a_m;
    logic [15:0]      b_m;

    logic             out4_valid, out8_valid, out16_valid;
    logic [7:0]       p4;
    logic [15:0]      p8;
    logic [31:0]      p16;
    logic             ret_valid;
    logic [31:0]      ret_prod;
    logic             ret_fire;

    // in_ready is only ever high in RUN, so it alone qualifies an issue.
    assign issue_fire = bus.in_ready && bus.in_valid;
    assign a_m        = mask_operand(mode_q, bus.a);
    assign b_m        = mask_operand(mode_q, bus.b);

    mul16_progressive #(.WIDTH(16)) u_mul (
        .clk         (clk),
        .rst_n       (~rst),
        .in_valid    (issue_fire),
        .a           (a_m),
        .b           (b_m),
        .out4_valid  (out4_valid),
        .p4          (p4),
        .out8_valid  (out8_valid),
        .p8          (p8),
        .out16_valid (out16_valid),
        .p16         (p16)
    );

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        ret_valid = 1'b0;
        ret_prod  = '0;
        case (mode_q)
            PREC_INT4: begin
                ret_valid = out4_valid;
                ret_prod  = 32'(p4);
            end
            PREC_INT8: begin
                ret_valid = out8_valid;
                ret_prod  = 32'(p8);
            end
            default: begin
                ret_valid = out16_valid;
                ret_prod  = p16;
            end
        endcase
    end

    assign ret_fire       = ret_valid && ((state == RUN) || (state == DRAIN));
    assign len_clamped    = (int'(bus.len) > MAX_LEN) ? LEN_W'(MAX_LEN) : bus.len;
    assign issue_cnt_nxt  = issue_cnt + LEN_W'(issue_fire);
    assign retire_cnt_nxt = retire_cnt + LEN_W'(ret_fire);
    assign acc_nxt        = acc + (ret_fire ? ACC_W'(ret_prod) : '0);

    // NOTE: all state here is sequential, so only non-blocking assignments are used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            mode_q        <= PREC_INT4;
            len_q         <= '0;
            issue_cnt     <= '0;
            retire_cnt    <= '0;
            acc           <= '0;
            bus.in_ready  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_mode  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode_q       <= prec_mode_e'(bus.mode);
                        len_q        <= len_clamped;
                        issue_cnt    <= '0;
                        retire_cnt   <= '0;
                        acc          <= '0;
                        bus.res_mode <= bus.mode;
                        bus.busy     <= 1'b1;
                        if (len_clamped == '0) begin
                            state         <= DONE;
                            bus.res_valid <= 1'b1;
                            bus.res_data  <= '0;
                        end else begin
                            state        <= RUN;
                            bus.in_ready <= 1'b1;
                        end
                    end
                end
                RUN, DRAIN: begin
                    issue_cnt  <= issue_cnt_nxt;
                    retire_cnt <= retire_cnt_nxt;
                    acc        <= acc_nxt;
                    if (ret_fire && (retire_cnt_nxt == len_q)) begin
                        state         <= DONE;
                        bus.in_ready  <= 1'b0;
                        bus.res_valid <= 1'b1;
                        bus.res_data  <= acc_nxt;
                    end else if (issue_cnt_nxt == len_q) begin
                        state        <= DRAIN;
                        bus.in_ready <= 1'b0;
                    end else begin
                        bus.in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state         <= IDLE;
                        bus.res_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
